mux_sel_arbiter: RTL

Round-robin arbiter and scheduler for the shared 3:1 select mux (`comp_case` datapath).
- Three requesters compete for the mux; the block drives the mux `sel` so that exactly one input is routed at a time.
- Each grant is held for a bounded dwell window.
- `sel` never takes the undefined code 2'b11.

---
 rtl/mux_sel_pkg.sv | 8 +
 rtl/mux_sel_arbiter_rr_pick.sv | 18 +
 rtl/mux_sel_arbiter.sv | 71 +++++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared widths, FSM state type and reset constants for the mux select arbiter
package mux_sel_pkg;
  localparam int NREQ = 3;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [SEL_W-1:0] SEL_RESET = 2'b00;
  localparam logic [SEL_W-1:0] LAST_RESET = 2'd2;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of req starting at start (start 3 treated as 0); found=any req, idx=first hit
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] i0, i1, i2;
  always_comb begin
    i0 = start == 2'd3 ? 2'd0 : start;
    i1 = i0 == 2'd2 ? 2'd0 : i0 + 2'd1;
    i2 = i1 == 2'd2 ? 2'd0 : i1 + 2'd1;
    found = |req;
    idx = req[i0] ? i0 : req[i1] ? i1 : i2;
  end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin 3:1 mux scheduler with min/max dwell; ports clk, reset (sync active-low), req[2:0] -> sel[1:0], grant[2:0], busy, switch_p
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MIN_DWELL = 2,
  parameter int MAX_DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             switch_p
);
  state_t state, state_n;
  logic [SEL_W-1:0] cur, cur_n, last, last_n, pick_start, pick_idx;
  logic [3:0] cnt, cnt_n;
  logic [NREQ-1:0] cur_oh, pick_req;
  logic found, rel, sw_n;
  assign cur_oh = NREQ'(1) << cur;
  rr_pick u_pick (.req(pick_req), .start(pick_start), .found(found), .idx(pick_idx));
  // While granted, only the other requesters compete and the search starts after cur
  always_comb begin
    pick_req = state == GRANT ? req & ~cur_oh : req;
    pick_start = (state == GRANT ? cur : last) + 2'd1;
    rel = cnt == 4'(MAX_DWELL - 1) || (!req[cur] && cnt >= 4'(MIN_DWELL - 1));
    state_n = state;
    cur_n = cur;
    last_n = last;
    cnt_n = cnt == 4'd15 ? cnt : cnt + 4'd1;
    sw_n = 1'b0;
    if (cur == 2'd3) begin
      state_n = IDLE;
      cur_n = SEL_RESET;
      cnt_n = '0;
    end else if (state == IDLE) begin
      cnt_n = '0;
      if (found) begin
        state_n = GRANT;
        cur_n = pick_idx;
        sw_n = 1'b1;
      end
    end else if (rel) begin
      last_n = cur;
      cnt_n = '0;
      if (found) begin
        cur_n = pick_idx;
        sw_n = 1'b1;
      end else if (!req[cur]) state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cur <= SEL_RESET;
      last <= LAST_RESET;
      cnt <= '0;
      switch_p <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      last <= last_n;
      cnt <= cnt_n;
      switch_p <= sw_n;
    end
  end
  assign busy = state == GRANT;
  assign grant = busy ? cur_oh : '0;
  assign sel = cur;
endmodule
